coin_payout_ctrl: RTL
=====================

Name: coin_payout_ctrl

Overview:
- Change-payout controller: the output side of the coin vending logic. The vending FSM consumes coin pulses; this block produces them, ejecting 5- and 10-unit coins from a two-tube hopper to pay out a requested amount.
- Tracks the coin inventory in each tube, checks that a request can be paid before ejecting anything, and handshakes every coin with the hopper using an eject/ack pair with timeout.
- Sits between the vending FSM's change request and the hopper mechanism.

Parameters:
AMT_W, 4, width of request amount in 5-unit steps (max 15 = 75 units)
CNT_W, 6, width of each tube inventory counter
TIMEOUT, 15, cycles allowed for eject_ack after an eject pulse (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  payout request strobe
req_units  input  AMT_W  amount to pay, in 5-unit steps
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready at the clock edge
refill  input  1  load inventory strobe
refill5  input  CNT_W  new 5-coin tube count
refill10  input  CNT_W  new 10-coin tube count
eject5  output  1  one-cycle command: drop one 5-coin
eject10  output  1  one-cycle command: drop one 10-coin
eject_ack  input  1  hopper confirms the commanded coin dropped
done  output  1  one-cycle pulse: payout complete
error  output  1  one-cycle pulse: request rejected, insufficient inventory
jam  output  1  high while in JAM
inv5  output  CNT_W  current 5-coin inventory
inv10  output  CNT_W  current 10-coin inventory

Behaviour:
- Reset (rst=0, async): state IDLE; remaining, timer, inv5 and inv10 cleared to 0; all pulse outputs and jam are 0; req_ready is 1 after release.
- Outputs are decoded from the registered state (Moore). Inventory and remaining are registers.
- IDLE: req_ready=1. On an accepted request, latch remaining=req_units and go to CHECK. Stray eject_ack is ignored.
- Refill: refill is honoured only in IDLE and loads inv5/inv10 at that edge. If refill and an accepted request arrive in the same edge, both happen, and CHECK sees the refilled counts. In all other states refill is ignored.
- CHECK (1 cycle):
  - n10 = min(inv10, remaining>>1); feasible if remaining - 2*n10 <= inv5.
  - Evaluate at width max(AMT_W,CNT_W)+1; no overflow is permitted.
  - remaining==0 -> DONE. Feasible -> EJECT. Not feasible -> REJECT.
- REJECT: error=1 for 1 cycle, then IDLE. Inventory is unchanged and no eject is issued.
- EJECT (1 cycle): if remaining>=2 and inv10>0, eject10=1; otherwise eject5=1. Record the coin type, clear the timer, go to WAIT_ACK. Never both ejects in one cycle.
- WAIT_ACK:
  - timer increments each cycle.
  - On eject_ack: decrement remaining by 2 (10-coin) or 1 (5-coin), and decrement the matching inventory counter. Go to DONE if the new remaining is 0, else EJECT.
  - If no ack in TIMEOUT cycles: an ack in the TIMEOUT-th WAIT_ACK cycle still counts. Otherwise JAM on the following edge, with remaining and inventory frozen.
- DONE: done=1 for 1 cycle, then IDLE.
- JAM: jam=1, req_ready=0, eject_ack ignored. Exits only via reset.
- Latency: request accepted at edge N -> CHECK in cycle N+1 -> first eject or error in cycle N+2. A zero request gives done in cycle N+2.
- Coin selection is greedy (10s first), so a feasible request always completes with exactly the planned coin mix.
- Reset mid-payout aborts immediately. No pulse is emitted and inventory is lost (0), so a refill is required.

Optional Feature:
- Macro PAYOUT_AUDIT_EN.
- Defined: adds output port audit_units (16 bits). It accumulates units paid, +1 per acknowledged 5-coin and +2 per acknowledged 10-coin. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Refill 5s=3, 10s=2; request 5; ack each eject 2 cycles later -> eject10, eject10, eject5 in order; done pulse once; inv5=2, inv10=0.
- inv5=1, inv10=1; request 4 -> error pulse in cycle N+2; no eject5/eject10; inventory unchanged; req_ready high again next cycle.
- inv5=0, inv10=3; request 3 -> error (odd remainder unpayable). Then request 0 -> done in cycle N+2 with no ejects.
- Request 1 with no ack -> after eject5, jam rises after TIMEOUT=15 cycles. req_ready stays 0, later acks are ignored, and jam holds until rst low.
- Ack arriving exactly in the 15th WAIT_ACK cycle is accepted, with no jam. Refill pulsed during WAIT_ACK is ignored (inv unchanged).
- rst asserted in WAIT_ACK -> all outputs 0 and inv5/inv10=0 immediately. After release, IDLE with req_ready=1. With PAYOUT_AUDIT_EN, audit_units=0.

Source files
------------

// File: rtl/coin_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coin_payout_ctrl
// Brief    : Change-payout controller; ejects 5/10-unit coins from a two-tube
//            hopper with inventory tracking and eject/ack timeout handling.
//            Optional macro PAYOUT_AUDIT_EN adds a saturating audit_units port.
// Revision : 1.0 - initial release
// ============================================================================
module coin_payout_ctrl #(
    parameter int AMT_W   = 4,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_units,
    output logic             req_ready,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill5,
    input  logic [CNT_W-1:0] refill10,
    output logic             eject5,
    output logic             eject10,
    input  logic             eject_ack,
    output logic             done,
    output logic             error,
    output logic             jam,
    output logic [CNT_W-1:0] inv5,
    output logic [CNT_W-1:0] inv10
`ifdef PAYOUT_AUDIT_EN
    ,
    output logic [15:0]      audit_units
`endif
);

    localparam int C_WIDE_W = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;
    localparam int C_TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [C_TMR_W-1:0] C_TMO_LAST = C_TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_REJECT   = 3'd2,
        S_EJECT    = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DONE     = 3'd5,
        S_JAM      = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [AMT_W-1:0]     r_remaining;
    logic [C_TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]     r_inv5;
    logic [CNT_W-1:0]     r_inv10;
    logic                 r_coin10;

    logic [C_WIDE_W-1:0]  w_rem_wide;
    logic [C_WIDE_W-1:0]  w_inv10_wide;
    logic [C_WIDE_W-1:0]  w_half;
    logic [C_WIDE_W-1:0]  w_n10;
    logic [C_WIDE_W-1:0]  w_left5;
    logic                 w_feasible;
    logic                 w_use10;
    logic [AMT_W-1:0]     w_rem_after_ack;

    // Plan check in a widened domain so 2*n10 and the remainder never wrap.
    always_comb begin
        w_rem_wide   = C_WIDE_W'(r_remaining);
        w_inv10_wide = C_WIDE_W'(r_inv10);
        w_half       = w_rem_wide >> 1;
        w_n10        = (w_inv10_wide < w_half) ? w_inv10_wide : w_half;
        w_left5      = w_rem_wide - (w_n10 << 1);
        w_feasible   = (w_left5 <= C_WIDE_W'(r_inv5));
        w_use10      = (w_rem_wide >= C_WIDE_W'(2)) && (r_inv10 != '0);
    end

    assign w_rem_after_ack = r_coin10 ? (r_remaining - AMT_W'(2))
                                      : (r_remaining - AMT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        eject5       = 1'b0;
        eject10      = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        jam          = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_remaining == '0) begin
                    w_state_next = S_DONE;
                end else if (w_feasible) begin
                    w_state_next = S_EJECT;
                end else begin
                    w_state_next = S_REJECT;
                end
            end
            S_REJECT: begin
                error        = 1'b1;
                w_state_next = S_IDLE;
            end
            S_EJECT: begin
                eject10      = w_use10;
                eject5       = ~w_use10;
                w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack in the last allowed cycle wins over the timeout.
                if (eject_ack) begin
                    w_state_next = (w_rem_after_ack == '0) ? S_DONE : S_EJECT;
                end else if (r_timer == C_TMO_LAST) begin
                    w_state_next = S_JAM;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            S_JAM: begin
                jam = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_remaining <= '0;
            r_timer     <= '0;
            r_inv5      <= '0;
            r_inv10     <= '0;
            r_coin10    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (refill) begin
                        r_inv5  <= refill5;
                        r_inv10 <= refill10;
                    end
                    if (req_valid) begin
                        r_remaining <= req_units;
                    end
                end
                S_EJECT: begin
                    r_coin10 <= w_use10;
                    r_timer  <= '0;
                end
                S_WAIT_ACK: begin
                    r_timer <= r_timer + C_TMR_W'(1);
                    if (eject_ack) begin
                        r_remaining <= w_rem_after_ack;
                        if (r_coin10) begin
                            r_inv10 <= r_inv10 - CNT_W'(1);
                        end else begin
                            r_inv5 <= r_inv5 - CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign inv5  = r_inv5;
    assign inv10 = r_inv10;

`ifdef PAYOUT_AUDIT_EN
    logic [15:0] r_audit;
    logic [16:0] w_audit_sum;

    assign w_audit_sum = {1'b0, r_audit} + (r_coin10 ? 17'd2 : 17'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_audit <= '0;
        end else if ((r_state == S_WAIT_ACK) && eject_ack) begin
            r_audit <= w_audit_sum[16] ? 16'hFFFF : w_audit_sum[15:0];
        end
    end

    assign audit_units = r_audit;
`endif

endmodule
`default_nettype wire
